// File: rtl/uart_loader.sv
// UART program loader: receives framed sections over rx_i and writes little-endian words to instruction ROM / data RAM.
// Optional idle timeout is compiled in with `define UART_LOADER_TIMEOUT_EN.
module uart_loader #(
  parameter int CLK_HZ      = 10_000_000,
  parameter int BAUD        = 115_200,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_TGT, S_CNTL, S_CNTH, S_DATA, S_DONE} ld_state_t;

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_vld;
  logic            frame_err;

  ld_state_t       ld_state_q, ld_state_d;
  logic            tgt_q, tgt_d;
  logic            last_q, last_d;
  logic [7:0]      cnt_lo_q, cnt_lo_d;
  logic [15:0]     rem_q, rem_d;
  logic [13:0]     adr_q, adr_d;
  logic [23:0]     asm_q, asm_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     dat_q, dat_d;
  logic            wen_q, wen_d;
  logic            err_q, err_d;

  // Both synchronizer stages and the edge-detect history idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= R_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = R_START;
      end
      R_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d  = '0;
          rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (bit_cnt_q == DIV_M1) begin
          bit_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (bit_cnt_q == DIV_M1) begin
          bit_cnt_d  = '0;
          rx_state_d = R_IDLE;
          if (rx_sync_q) byte_vld  = 1'b1;
          else           frame_err = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] idle_q, idle_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= '0;
    else      idle_q <= idle_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_q <= S_TGT;
      tgt_q      <= 1'b0;
      last_q     <= 1'b0;
      cnt_lo_q   <= '0;
      rem_q      <= '0;
      adr_q      <= '0;
      asm_q      <= '0;
      byte_idx_q <= '0;
      dat_q      <= '0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      tgt_q      <= tgt_d;
      last_q     <= last_d;
      cnt_lo_q   <= cnt_lo_d;
      rem_q      <= rem_d;
      adr_q      <= adr_d;
      asm_q      <= asm_d;
      byte_idx_q <= byte_idx_d;
      dat_q      <= dat_d;
      wen_q      <= wen_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    tgt_d      = tgt_q;
    last_d     = last_q;
    cnt_lo_d   = cnt_lo_q;
    rem_d      = rem_q;
    adr_d      = adr_q;
    asm_d      = asm_q;
    byte_idx_d = byte_idx_q;
    dat_d      = dat_q;
    wen_d      = 1'b0;
    err_d      = err_q;
`ifdef UART_LOADER_TIMEOUT_EN
    idle_d     = '0;
`endif

    // The section is left only after its final strobe, so the strobe is always seen in S_DATA.
    if (wen_q) begin
      adr_d = adr_q + 14'd1;
      rem_d = rem_q - 16'd1;
      if (rem_q == 16'd1) ld_state_d = last_q ? S_DONE : S_TGT;
    end

    if (frame_err) begin
      err_d = 1'b1;
      if (ld_state_q != S_DONE) begin
        ld_state_d = S_TGT;
        byte_idx_d = '0;
      end
    end else if (byte_vld) begin
      case (ld_state_q)
        S_TGT: begin
          if (shift_q[6:0] == 7'd0 || shift_q[6:0] == 7'd1) begin
            tgt_d      = shift_q[0];
            last_d     = shift_q[7];
            ld_state_d = S_CNTL;
          end
        end
        S_CNTL: begin
          cnt_lo_d   = shift_q;
          adr_d      = '0;
          ld_state_d = S_CNTH;
        end
        S_CNTH: begin
          rem_d      = {shift_q, cnt_lo_q};
          adr_d      = '0;
          byte_idx_d = '0;
          if ({shift_q, cnt_lo_q} == 16'd0) ld_state_d = last_q ? S_DONE : S_TGT;
          else                              ld_state_d = S_DATA;
        end
        S_DATA: begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            dat_d = {shift_q, asm_q};
            wen_d = 1'b1;
          end else begin
            asm_d = {shift_q, asm_q[23:8]};
          end
        end
        default: ;
      endcase
    end

`ifdef UART_LOADER_TIMEOUT_EN
    if (ld_state_q == S_CNTL || ld_state_q == S_CNTH || ld_state_q == S_DATA) begin
      if (byte_vld) begin
        idle_d = '0;
      end else if (idle_q == TO_M1) begin
        idle_d     = '0;
        err_d      = 1'b1;
        ld_state_d = S_TGT;
        byte_idx_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = {tgt_q, adr_q};
  assign upg_dat_o  = dat_q;
  assign upg_done_o = (ld_state_q == S_DONE);
  assign busy_o     = (ld_state_q != S_TGT) && (ld_state_q != S_DONE);
  assign err_o      = err_q;

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10_000_000, which is the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, which is the UART bit rate; DIV = CLK_HZ/BAUD (integer, truncated) clocks per bit.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1_000_000, which is the idle limit in clocks, used only when the timeout feature is compiled in.
REQ-004 clk  input  1  system clock, single domain.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 rx_i  input  1  UART receive line, idle high, asynchronous to clk.
REQ-007 upg_wen_o  output  1  one-cycle memory write strobe.
REQ-008 upg_adr_o  output  15  [14] = target (0 instruction ROM, 1 data RAM); [13:0] = word address.
REQ-009 upg_dat_o  output  32  assembled word, little-endian.
REQ-010 upg_done_o  output  1  program load complete; the CPU may run.
REQ-011 busy_o  output  1  a section is in progress (state is not S_TGT or S_DONE).
REQ-012 err_o  output  1  sticky error flag: framing error or timeout.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchronizer, both flops resetting to 1.
REQ-014 Byte receiver SHALL be an FSM R_IDLE -> R_START -> R_DATA -> R_STOP.
- R_START is entered on a synchronized falling edge.
- Start bit is re-sampled at DIV/2; if it is high, return to R_IDLE (glitch).
- 8 data bits, LSB first, each sampled at DIV/2 + k*DIV.
- Stop bit is sampled one DIV later.
REQ-015 A stop bit of 1 SHALL produce a one-cycle internal byte_vld; a stop bit of 0 SHALL discard the byte, set err_o, and abort the current section to S_TGT.
REQ-016 Loader FSM states SHALL be S_TGT, S_CNTL, S_CNTH, S_DATA, S_DONE.
REQ-017 In S_TGT, target byte handling SHALL be:
- Byte[6:0] = 0 or 1 latches target = byte[0] and last = byte[7], and goes to S_CNTL.
- Any other byte is ignored (stay in S_TGT).
REQ-018 S_CNTL/S_CNTH SHALL capture the 16-bit word count N, low byte first, and clear the word address to 0.
REQ-019 On the S_CNTH byte, N = 0 SHALL end the section immediately with no writes.
REQ-020 S_DATA SHALL shift bytes into upg_dat_o little-endian (first byte -> [7:0]).
REQ-021 On the 4th byte of a word, upg_wen_o SHALL pulse high for exactly the next clock with the current upg_adr_o; the address increments by 1 in the cycle after the pulse.
REQ-022 The 14-bit word address SHALL wrap from 16383 to 0 when N > 16384; writes continue.
REQ-023 Section end: after the N-th write, go to S_DONE if last = 1, otherwise to S_TGT.
REQ-024 S_DONE SHALL hold upg_done_o = 1 and ignore all further bytes until reset.
REQ-025 upg_dat_o and upg_adr_o SHALL hold their values between strobes.
REQ-026 A framing error in the middle of a word SHALL discard the partial word with no write.
REQ-027 upg_wen_o SHALL never assert in S_TGT, S_CNTL, S_CNTH, or S_DONE.

Reset
REQ-028 On rst low, values SHALL be forced immediately:
- Both FSMs return to their idle states (R_IDLE, S_TGT).
- upg_wen_o = 0, upg_adr_o = 0, upg_dat_o = 0.
- upg_done_o = 0, busy_o = 0, err_o = 0.
- All counters = 0.
REQ-029 Reset asserted mid-byte or mid-section SHALL abandon the section with no partial write; loading resumes from S_TGT after release.

Configuration
REQ-030 Macro UART_LOADER_TIMEOUT_EN:
- When defined: an idle counter runs only while in S_CNTL, S_CNTH, or S_DATA, and clears on each byte_vld. When it reaches TIMEOUT_CYC, err_o is set and the FSM returns to S_TGT.
- When undefined: no counter exists and the loader waits indefinitely.

Verification
Benches SHALL use CLK_HZ = 1_000_000 and BAUD = 100_000 (DIV = 10).
REQ-031 Single word:
- Stimulus: bytes 0x80, 0x01, 0x00, 0x78, 0x56, 0x34, 0x12.
- Response: one upg_wen_o pulse with adr = 0x0000 and dat = 0x12345678; upg_done_o rises; err_o = 0.
REQ-032 Two sections:
- Stimulus: 0x00, N = 2, 8 data bytes; then 0x81, N = 1, 0xEF, 0xBE, 0xAD, 0xDE.
- Response: writes at adr 0x0000 and 0x0001, then 0x4000 with dat = 0xDEADBEEF; upg_done_o asserts only after the third write.
REQ-033 Framing error:
- Stimulus: 0x80, N = 1, 2 data bytes, then a byte with stop bit = 0.
- Response: err_o = 1, no write, state S_TGT, busy_o = 0.
REQ-034 Reset mid-word:
- Stimulus: rst low for 3 clocks after 2 data bytes, then a full valid load.
- Response: all outputs read 0 during reset; the subsequent load is correct and starts at adr 0.
REQ-035 Boundary:
- Stimulus: N = 0 with target 0x81.
- Response: zero writes, upg_done_o = 1; subsequent bytes produce no writes.
REQ-036 Timeout (UART_LOADER_TIMEOUT_EN defined, TIMEOUT_CYC = 500):
- Stimulus: 0x80, N = 1, one data byte, then the line held idle.
- Response: err_o is set 500 clocks after the last byte_vld, state returns to S_TGT, and no write occurs.
